cook_timer: RTL

COOK_TIMER -- requirements
Module: cook_timer

---
 rtl/cook_timer.sv | 107 ++++++++++
 1 files changed

// File: rtl/cook_timer.sv
// Microwave cook timer: magnetron SR latch, keypad entry of a four-digit BCD
// time, and a prescaled one-second BCD countdown while cooking.
module cook_timer #(
  parameter int TICK_DIV = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       S,
  input  logic       R,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] digit,
  output logic       mag_on,
  output logic       timer_done,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
  } bcd_time_t;

  bcd_time_t     time_q, time_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  // Borrow chain: ones -> tens -> minutes. Tens digits above 5 from keypad
  // entry are simply counted down, so 00:90 really lasts 90 seconds.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t n;
    n = t;
    if (t != '0) begin
      if (t.so != 4'd0) begin
        n.so = t.so - 4'd1;
      end else begin
        n.so = 4'd9;
        if (t.st != 4'd0) begin
          n.st = t.st - 4'd1;
        end else begin
          n.st = 4'd5;
          if (t.mo != 4'd0) begin
            n.mo = t.mo - 4'd1;
          end else begin
            n.mo = 4'd9;
            n.mt = t.mt - 4'd1;
          end
        end
      end
    end
    return n;
  endfunction

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    presc_d = presc_q;
    time_d  = time_q;
    tick    = mag_on && (presc_q == PRESC_LAST);
    if (clear) begin
      presc_d = '0;
      time_d  = '0;
    end else begin
      // Prescaler freezes while paused so resuming keeps the partial second.
      if (mag_on) begin
        presc_d = tick ? '0 : presc_q + 1'b1;
      end
      if (tick) begin
        time_d = bcd_dec(time_q);
      end else if (load && !mag_on && (digit <= 4'd9)) begin
        time_d = '{mt: time_q.mo, mo: time_q.st, st: time_q.so, so: digit};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      mag_on     <= 1'b0;
      presc_q    <= '0;
      time_q     <= '0;
      timer_done <= 1'b1;
    end else begin
      if (R) begin
        mag_on <= 1'b0;
      end else if (S) begin
        mag_on <= 1'b1;
      end
      presc_q    <= presc_d;
      time_q     <= time_d;
      // Flags the digits as they stand now, so it lags the digits by one clock.
      timer_done <= (time_q == '0);
    end
  end

  assign min_tens = time_q.mt;
  assign min_ones = time_q.mo;
  assign sec_tens = time_q.st;
  assign sec_ones = time_q.so;

endmodule
